// File: rtl/ppu_bus_arbiter_if.sv
// ppu_bus_arbiter_if
//   CPU-side bus between the system MMU and the PPU bus arbiter.
//   A_mmu  : CPU address
//   Di_mmu : CPU write data
//   Do_mmu : read data returned to the CPU (combinational in the arbiter)
//   wr_mmu : write strobe, one cycle per access
//   rd_mmu : read strobe, one cycle per access
//   master : the MMU/CPU side; slave : the arbiter
interface ppu_bus_arbiter_if;
  logic [15:0] A_mmu;
  logic [7:0]  Di_mmu;
  logic [7:0]  Do_mmu;
  logic        wr_mmu;
  logic        rd_mmu;

  modport master (output A_mmu, Di_mmu, wr_mmu, rd_mmu, input Do_mmu);
  modport slave  (input  A_mmu, Di_mmu, wr_mmu, rd_mmu, output Do_mmu);
endinterface

// File: rtl/ppu_bus_arbiter.sv
// ppu_bus_arbiter
//   Routes CPU accesses to VRAM, OAM and the PPU register window, applies the
//   PPU-mode access locks and runs the OAM DMA engine.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   bus (slave)         : CPU address/data/strobes and read data
//   *_vram              : VRAM port, address relative to VRAM_BASE
//   *_oam               : OAM port, address relative to OAM_BASE; owned by
//                         the DMA engine while dma_active is high
//   ppu_regs            : register read-back, byte k is REG_BASE+k
//   reg_wr/idx/wdata    : register write strobe, index and data
//   lcd_on, ppu_mode    : inputs to the access locks
//   dma_A/dma_rd/dma_Di : DMA source bus, data valid the cycle after dma_rd
//   dma_active          : DMA in progress
module ppu_bus_arbiter #(
  parameter logic [15:0] VRAM_BASE = 16'h8000,
  parameter logic [15:0] VRAM_SIZE = 16'h2000,
  parameter logic [15:0] OAM_BASE  = 16'hFE00,
  parameter int unsigned OAM_SIZE  = 160,
  parameter logic [15:0] REG_BASE  = 16'hFF40,
  parameter int unsigned NUM_REGS  = 12,
  parameter int unsigned DMA_IDX   = 6,
  parameter bit          LOCK_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  ppu_bus_arbiter_if.slave      bus,
  output logic [15:0]           A_vram,
  output logic [7:0]            Do_vram,
  input  logic [7:0]            Di_vram,
  output logic                  wr_vram,
  output logic                  rd_vram,
  output logic [15:0]           A_oam,
  output logic [7:0]            Do_oam,
  input  logic [7:0]            Di_oam,
  output logic                  wr_oam,
  output logic                  rd_oam,
  input  logic [8*NUM_REGS-1:0] ppu_regs,
  output logic                  reg_wr,
  output logic [3:0]            reg_idx,
  output logic [7:0]            reg_wdata,
  input  logic                  lcd_on,
  input  logic [1:0]            ppu_mode,
  output logic [15:0]           dma_A,
  output logic                  dma_rd,
  input  logic [7:0]            dma_Di,
  output logic                  dma_active
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_READ, S_WRITE} dma_state_e;

  // Window ends are computed one bit wider so a window touching 16'hFFFF
  // does not wrap.
  localparam logic [16:0] VRAM_END = {1'b0, VRAM_BASE} + {1'b0, VRAM_SIZE};
  localparam logic [16:0] OAM_END  = {1'b0, OAM_BASE} + 17'(OAM_SIZE);
  localparam logic [16:0] REG_END  = {1'b0, REG_BASE} + 17'(NUM_REGS);
  localparam logic [7:0]  LAST_IDX = 8'(OAM_SIZE - 1);

  dma_state_e  state_q;
  logic [7:0]  idx_q;
  logic [7:0]  dma_reg_q;     // DMA register; doubles as the source high byte
  logic        dma_active_q;
  logic        dma_rd_q;
  logic        dma_wr_q;

  logic [16:0] addr_x;
  logic        cs_vram, cs_oam, cs_reg;
  logic [15:0] vram_off, oam_off, reg_off;
  logic        vram_lock, oam_lock;
  logic        dma_reg_wr;
  logic [7:0]  reg_rdata;

  // ---------------------------------------------------------------- decode
  assign addr_x  = {1'b0, bus.A_mmu};
  assign cs_vram = (addr_x >= {1'b0, VRAM_BASE}) && (addr_x < VRAM_END);
  assign cs_oam  = (addr_x >= {1'b0, OAM_BASE})  && (addr_x < OAM_END);
  assign cs_reg  = (addr_x >= {1'b0, REG_BASE})  && (addr_x < REG_END);

  assign vram_off = bus.A_mmu - VRAM_BASE;
  assign oam_off  = bus.A_mmu - OAM_BASE;
  assign reg_off  = bus.A_mmu - REG_BASE;

  // Locks follow ppu_mode combinationally so a mode change applies at once.
  assign vram_lock = LOCK_EN && lcd_on && (ppu_mode == 2'd3);
  assign oam_lock  = dma_active_q || (LOCK_EN && lcd_on && (ppu_mode >= 2'd2));

  // --------------------------------------------------------------- VRAM port
  // Strobes are masked by rst so nothing reaches a memory while reset is held.
  assign A_vram  = vram_off;
  assign Do_vram = bus.Di_mmu;
  assign wr_vram = bus.wr_mmu && cs_vram && !vram_lock && !rst;
  assign rd_vram = bus.rd_mmu && cs_vram && !vram_lock && !rst;

  // ---------------------------------------------------------------- OAM port
  // The DMA engine owns the port for its whole run; the CPU path is already
  // shut off by oam_lock, so only the address/data mux needs dma_active_q.
  assign A_oam  = dma_active_q ? {8'h00, idx_q} : oam_off;
  assign Do_oam = dma_active_q ? dma_Di : bus.Di_mmu;
  assign wr_oam = dma_active_q ? (dma_wr_q && !rst)
                               : (bus.wr_mmu && cs_oam && !oam_lock && !rst);
  assign rd_oam = bus.rd_mmu && cs_oam && !oam_lock && !rst;

  // ------------------------------------------------------- register window
  assign reg_wr     = bus.wr_mmu && cs_reg && !rst;
  assign reg_idx    = reg_off[3:0];
  assign reg_wdata  = bus.Di_mmu;
  assign dma_reg_wr = reg_wr && (reg_off == 16'(DMA_IDX));

  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first;
    // a path that skips the assignment would otherwise infer a latch.
    reg_rdata = 8'h00;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (reg_off == 16'(k)) reg_rdata = ppu_regs[8*k +: 8];
    end
    if (reg_off == 16'(DMA_IDX)) reg_rdata = dma_reg_q;
  end

  // -------------------------------------------------------------- read path
  always_comb begin
    bus.Do_mmu = 8'h00;
    if (cs_vram)     bus.Do_mmu = vram_lock ? 8'hFF : Di_vram;
    else if (cs_oam) bus.Do_mmu = oam_lock  ? 8'hFF : Di_oam;
    else if (cs_reg) bus.Do_mmu = reg_rdata;
  end

  // ---------------------------------------------------------------- DMA FSM
  assign dma_A      = {dma_reg_q, 8'h00} + {8'h00, idx_q};
  assign dma_rd     = dma_rd_q && !rst;
  assign dma_active = dma_active_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge.
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= 8'h00;
      dma_reg_q    <= 8'h00;
      dma_active_q <= 1'b0;
      dma_rd_q     <= 1'b0;
      dma_wr_q     <= 1'b0;
    end else if (dma_reg_wr) begin
      // A write to the DMA register (re)starts the transfer from any state;
      // an OAM write in progress this cycle still completes.
      state_q      <= S_START;
      idx_q        <= 8'h00;
      dma_reg_q    <= bus.Di_mmu;
      dma_active_q <= 1'b1;
      dma_rd_q     <= 1'b0;
      dma_wr_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          dma_active_q <= 1'b0;
          dma_rd_q     <= 1'b0;
          dma_wr_q     <= 1'b0;
        end
        S_START: begin
          state_q  <= S_READ;
          dma_rd_q <= 1'b1;
        end
        S_READ: begin
          state_q  <= S_WRITE;
          dma_rd_q <= 1'b0;
          dma_wr_q <= 1'b1;
        end
        S_WRITE: begin
          dma_wr_q <= 1'b0;
          idx_q    <= idx_q + 8'd1;
          if (idx_q < LAST_IDX) begin
            state_q  <= S_READ;
            dma_rd_q <= 1'b1;
          end else begin
            state_q      <= S_IDLE;
            dma_active_q <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_bus_arbiter.sv
// tb_ppu_bus_arbiter
//   Randomised bench for ppu_bus_arbiter. The DMA reference is a timeline:
//   t counts cycles since the DMA register write (t=1 is START), and the
//   expected strobes, addresses and data follow from t arithmetically.
module tb_ppu_bus_arbiter;

  localparam int DMA_CYCLES = 321;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] A_vram, A_oam, dma_A;
  logic [7:0]  Do_vram, Do_oam, Di_vram, Di_oam, dma_Di, reg_wdata;
  logic        wr_vram, rd_vram, wr_oam, rd_oam, reg_wr, dma_rd, dma_active;
  logic [3:0]  reg_idx;
  logic [95:0] ppu_regs;
  logic        lcd_on;
  logic [1:0]  ppu_mode;

  ppu_bus_arbiter_if bus ();

  ppu_bus_arbiter dut (
    .clk(clk), .rst(rst), .bus(bus),
    .A_vram(A_vram), .Do_vram(Do_vram), .Di_vram(Di_vram), .wr_vram(wr_vram), .rd_vram(rd_vram),
    .A_oam(A_oam), .Do_oam(Do_oam), .Di_oam(Di_oam), .wr_oam(wr_oam), .rd_oam(rd_oam),
    .ppu_regs(ppu_regs), .reg_wr(reg_wr), .reg_idx(reg_idx), .reg_wdata(reg_wdata),
    .lcd_on(lcd_on), .ppu_mode(ppu_mode),
    .dma_A(dma_A), .dma_rd(dma_rd), .dma_Di(dma_Di), .dma_active(dma_active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int         t_model = 0;
  logic [7:0] base_model = 8'h00;
  logic [7:0] exp_dma_reg = 8'h00;
  int         act_seen = 0;
  int         wr_seen = 0;
  int         rd_seen = 0;

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return a[7:0] ^ {a[3:0], a[15:12]} ^ 8'h5A;
  endfunction

  task automatic cpu_set(input logic [15:0] a, input logic [7:0] d, input logic wr, input logic rd);
    bus.A_mmu = a; bus.Di_mmu = d; bus.wr_mmu = wr; bus.rd_mmu = rd;
    #1;
  endtask

  // One clock cycle: check DMA outputs against the timeline, advance it,
  // then supply source data for any read issued this cycle.
  task automatic tick();
    logic        trig, cap_rd, exp_rd, exp_wr;
    logic [15:0] cap_a, exp_a;
    int          idx;
    #1;
    if (dma_active === 1'b1) act_seen++;
    if (dma_rd === 1'b1) rd_seen++;
    if (dma_active === 1'b1 && wr_oam === 1'b1) wr_seen++;
    checks++;
    if (dma_active !== (t_model >= 1 && t_model <= DMA_CYCLES)) begin
      failures++;
      $display("FAIL dma_active t=%0d: got %b", t_model, dma_active);
    end
    exp_rd = !rst && t_model >= 2 && t_model < DMA_CYCLES && (t_model % 2 == 0);
    checks++;
    if (dma_rd !== exp_rd) begin
      failures++;
      $display("FAIL dma_rd t=%0d: got %b expected %b", t_model, dma_rd, exp_rd);
    end
    if (exp_rd) begin
      exp_a = {base_model, 8'h00} + 16'((t_model - 2) / 2);
      checks++;
      if (dma_A !== exp_a) begin
        failures++;
        $display("FAIL dma_A t=%0d: got %h expected %h", t_model, dma_A, exp_a);
      end
    end
    if (t_model >= 1 && t_model <= DMA_CYCLES) begin
      exp_wr = !rst && t_model >= 3 && (t_model % 2 == 1);
      checks++;
      if (wr_oam !== exp_wr || rd_oam !== 1'b0) begin
        failures++;
        $display("FAIL dma_oam_strobe t=%0d: got wr=%b rd=%b expected wr=%b rd=0", t_model, wr_oam, rd_oam, exp_wr);
      end
      if (exp_wr) begin
        idx = (t_model - 3) / 2;
        exp_a = {base_model, 8'h00} + 16'(idx);
        checks++;
        if (A_oam !== 16'(idx) || Do_oam !== src_byte(exp_a)) begin
          failures++;
          $display("FAIL dma_oam_write idx=%0d: got A=%h D=%h expected A=%h D=%h",
                   idx, A_oam, Do_oam, 16'(idx), src_byte(exp_a));
        end
      end
    end
    trig   = !rst && bus.wr_mmu && (bus.A_mmu == 16'hFF46);
    cap_rd = dma_rd;
    cap_a  = dma_A;
    @(posedge clk);
    if (rst) begin
      t_model = 0; exp_dma_reg = 8'h00;
    end else if (trig) begin
      t_model = 1; base_model = bus.Di_mmu; exp_dma_reg = bus.Di_mmu;
    end else if (t_model > 0) begin
      t_model = (t_model == DMA_CYCLES) ? 0 : t_model + 1;
    end
    #1;
    dma_Di = cap_rd ? src_byte(cap_a) : 8'($urandom);
    bus.wr_mmu = 1'b0;
    bus.rd_mmu = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_set(16'h8010, 8'hAB, 1'b1, 1'b0);
    @(posedge clk); #2;
    checks++;
    if (wr_vram !== 1'b0 || reg_wr !== 1'b0 || wr_oam !== 1'b0 || dma_rd !== 1'b0) begin
      failures++;
      $display("FAIL reset_strobes: got wr_vram=%b reg_wr=%b wr_oam=%b dma_rd=%b expected 0", wr_vram, reg_wr, wr_oam, dma_rd);
    end
    checks++;
    if (dma_active !== 1'b0) begin
      failures++;
      $display("FAIL reset_dma_active: got %b expected 0", dma_active);
    end
    tick();
    rst = 1'b0;
    cpu_set(16'hFF46, 8'h00, 1'b0, 1'b1);
    checks++;
    if (bus.Do_mmu !== 8'h00) begin
      failures++;
      $display("FAIL reset_dma_reg: got %h expected 00", bus.Do_mmu);
    end
    tick();
  endtask

  task automatic test_vram();
    logic [15:0] off;
    logic [7:0]  d;
    logic        lock;
    for (int i = 0; i < 14; i++) begin
      if (i == 0) begin off = 16'h0010; d = 8'hAB; lcd_on = 1'b1; ppu_mode = 2'd0; end
      else if (i == 1) begin off = 16'h0010; d = 8'hAB; lcd_on = 1'b1; ppu_mode = 2'd3; end
      else begin
        off = 16'($urandom_range(0, 16'h1FFF)); d = 8'($urandom);
        lcd_on = 1'($urandom); ppu_mode = 2'($urandom);
      end
      lock = lcd_on && (ppu_mode == 2'd3);
      cpu_set(16'h8000 + off, d, 1'b1, 1'b0);
      checks++;
      if (wr_vram !== !lock || rd_vram !== 1'b0) begin
        failures++;
        $display("FAIL vram_write_strobe %h: got wr=%b rd=%b expected wr=%b", off, wr_vram, rd_vram, !lock);
      end
      if (!lock) begin
        checks++;
        if (A_vram !== off || Do_vram !== d) begin
          failures++;
          $display("FAIL vram_write_bus: got A=%h D=%h expected A=%h D=%h", A_vram, Do_vram, off, d);
        end
      end
      tick();
      Di_vram = 8'($urandom);
      cpu_set(16'h8000 + off, 8'h00, 1'b0, 1'b1);
      checks++;
      if (rd_vram !== !lock || bus.Do_mmu !== (lock ? 8'hFF : Di_vram)) begin
        failures++;
        $display("FAIL vram_read %h: got rd=%b Do=%h expected rd=%b Do=%h", off, rd_vram, bus.Do_mmu, !lock, lock ? 8'hFF : Di_vram);
      end
      tick();
    end
  endtask

  task automatic test_oam_lock();
    logic [15:0] off;
    logic [7:0]  d;
    logic        lock;
    lcd_on = 1'b1; ppu_mode = 2'd2; Di_oam = 8'h3C;
    cpu_set(16'hFE05, 8'h00, 1'b0, 1'b1);
    checks++;
    if (bus.Do_mmu !== 8'hFF || rd_oam !== 1'b0) begin
      failures++;
      $display("FAIL oam_locked_read: got Do=%h rd=%b expected Do=FF rd=0", bus.Do_mmu, rd_oam);
    end
    lcd_on = 1'b0;
    #1;
    checks++;
    if (bus.Do_mmu !== 8'h3C || rd_oam !== 1'b1 || A_oam !== 16'h0005) begin
      failures++;
      $display("FAIL oam_unlocked_read: got Do=%h rd=%b A=%h expected Do=3C rd=1 A=0005", bus.Do_mmu, rd_oam, A_oam);
    end
    tick();
    for (int i = 0; i < 10; i++) begin
      off = 16'($urandom_range(0, 159)); d = 8'($urandom);
      lcd_on = 1'($urandom); ppu_mode = 2'($urandom);
      lock = lcd_on && (ppu_mode >= 2'd2);
      cpu_set(16'hFE00 + off, d, 1'b1, 1'b0);
      checks++;
      if (wr_oam !== !lock || (!lock && (A_oam !== off || Do_oam !== d))) begin
        failures++;
        $display("FAIL oam_write %h: got wr=%b A=%h D=%h expected wr=%b A=%h D=%h", off, wr_oam, A_oam, Do_oam, !lock, off, d);
      end
      tick();
    end
  endtask

  task automatic test_decode();
    logic [15:0] addrs [14];
    int          region [14];   // 0 none, 1 vram, 2 oam, 3 reg
    logic [7:0]  exp_do, d;
    logic [15:0] ro;
    addrs = '{16'h7FFF, 16'h8000, 16'h9FFF, 16'hA000, 16'hFDFF, 16'hFE00, 16'hFE9F,
              16'hFEA0, 16'hFF3F, 16'hFF40, 16'hFF4B, 16'hFF4C, 16'hFFFF, 16'hFF42};
    region = '{0, 1, 1, 0, 0, 2, 2, 0, 0, 3, 3, 0, 0, 3};
    lcd_on = 1'b0; ppu_mode = 2'd0;
    for (int i = 0; i < 14; i++) begin
      ppu_regs = {$urandom, $urandom, $urandom};
      Di_vram = 8'($urandom); Di_oam = 8'($urandom);
      ro = addrs[i] - 16'hFF40;
      case (region[i])
        1: exp_do = Di_vram;
        2: exp_do = Di_oam;
        3: exp_do = (ro == 16'd6) ? exp_dma_reg : ppu_regs[8*ro[3:0] +: 8];
        default: exp_do = 8'h00;
      endcase
      cpu_set(addrs[i], 8'h00, 1'b0, 1'b1);
      checks++;
      if (bus.Do_mmu !== exp_do || rd_vram !== (region[i] == 1) || rd_oam !== (region[i] == 2)) begin
        failures++;
        $display("FAIL decode_read %h: got Do=%h rdv=%b rdo=%b expected Do=%h region=%0d", addrs[i], bus.Do_mmu, rd_vram, rd_oam, exp_do, region[i]);
      end
      tick();
      d = 8'($urandom);
      cpu_set(addrs[i], d, 1'b1, 1'b0);
      checks++;
      if (wr_vram !== (region[i] == 1) || wr_oam !== (region[i] == 2) || reg_wr !== (region[i] == 3)) begin
        failures++;
        $display("FAIL decode_write %h: got wv=%b wo=%b wr=%b region=%0d", addrs[i], wr_vram, wr_oam, reg_wr, region[i]);
      end
      if (region[i] == 3) begin
        checks++;
        if (reg_idx !== ro[3:0] || reg_wdata !== d) begin
          failures++;
          $display("FAIL reg_write %h: got idx=%0d d=%h expected idx=%0d d=%h", addrs[i], reg_idx, reg_wdata, ro[3:0], d);
        end
      end
      tick();
    end
  endtask

  task automatic test_dma(input logic [7:0] v);
    logic [7:0] d;
    lcd_on = 1'b1; ppu_mode = 2'd0;
    ppu_regs = {$urandom, $urandom, $urandom};
    cpu_set(16'hFF46, v, 1'b1, 1'b0);
    checks++;
    if (reg_wr !== 1'b1 || reg_idx !== 4'd6 || reg_wdata !== v) begin
      failures++;
      $display("FAIL dma_reg_write: got reg_wr=%b idx=%0d d=%h expected 1/6/%h", reg_wr, reg_idx, reg_wdata, v);
    end
    act_seen = 0; wr_seen = 0;
    tick();
    for (int i = 0; i < 330; i++) begin
      if (i == 10) begin
        Di_oam = 8'h77;
        cpu_set(16'hFE00, 8'h00, 1'b0, 1'b1);
        checks++;
        if (bus.Do_mmu !== 8'hFF) begin
          failures++;
          $display("FAIL dma_cpu_oam_read: got %h expected FF", bus.Do_mmu);
        end
      end else if (i == 11) begin
        cpu_set(16'hFF42, 8'h00, 1'b0, 1'b1);
        checks++;
        if (bus.Do_mmu !== ppu_regs[23:16]) begin
          failures++;
          $display("FAIL dma_cpu_reg_read: got %h expected %h", bus.Do_mmu, ppu_regs[23:16]);
        end
      end else if (i == 12) begin
        d = 8'($urandom);
        cpu_set(16'h8123, d, 1'b1, 1'b0);
        checks++;
        if (wr_vram !== 1'b1 || A_vram !== 16'h0123 || Do_vram !== d) begin
          failures++;
          $display("FAIL dma_cpu_vram_write: got wr=%b A=%h D=%h expected 1/0123/%h", wr_vram, A_vram, Do_vram, d);
        end
      end
      tick();
    end
    checks++;
    if (act_seen !== DMA_CYCLES || wr_seen !== 160) begin
      failures++;
      $display("FAIL dma_length: got active=%0d writes=%0d expected 321/160", act_seen, wr_seen);
    end
    cpu_set(16'hFF46, 8'h00, 1'b0, 1'b1);
    checks++;
    if (bus.Do_mmu !== v) begin
      failures++;
      $display("FAIL dma_reg_read: got %h expected %h", bus.Do_mmu, v);
    end
    tick();
  endtask

  task automatic test_restart();
    logic [7:0] v1, v2;
    int         n;
    v1 = 8'($urandom); v2 = 8'hD0;
    cpu_set(16'hFF46, v1, 1'b1, 1'b0);
    tick();
    n = 0;
    while (t_model != 103 && n < 300) begin tick(); n++; end
    checks++;
    if (t_model != 103) begin
      failures++;
      $display("FAIL restart_reach_idx50: got t=%0d expected 103", t_model);
    end
    // Restart lands on the WRITE cycle of idx 50; that write must still occur.
    cpu_set(16'hFF46, v2, 1'b1, 1'b0);
    tick();
    act_seen = 0; wr_seen = 0;
    for (int i = 0; i < 330; i++) begin
      if (i == 1) begin
        #1;
        checks++;
        if (dma_rd !== 1'b1 || dma_A !== 16'hD000) begin
          failures++;
          $display("FAIL restart_first_read: got rd=%b A=%h expected 1/D000", dma_rd, dma_A);
        end
      end
      tick();
    end
    checks++;
    if (act_seen !== DMA_CYCLES || wr_seen !== 160) begin
      failures++;
      $display("FAIL restart_length: got active=%0d writes=%0d expected 321/160", act_seen, wr_seen);
    end
  endtask

  task automatic test_reset_mid_dma();
    int n;
    cpu_set(16'hFF46, 8'($urandom), 1'b1, 1'b0);
    tick();
    n = 0;
    while (t_model != 51 && n < 100) begin tick(); n++; end
    rst = 1'b1;
    #1;
    checks++;
    if (wr_oam !== 1'b0 || dma_rd !== 1'b0) begin
      failures++;
      $display("FAIL reset_held_strobes: got wr_oam=%b dma_rd=%b expected 0", wr_oam, dma_rd);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (dma_active !== 1'b0 || wr_oam !== 1'b0) begin
      failures++;
      $display("FAIL reset_abort: got dma_active=%b wr_oam=%b expected 0", dma_active, wr_oam);
    end
    rd_seen = 0;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (rd_seen !== 0) begin
      failures++;
      $display("FAIL reset_no_reads: got %0d dma_rd cycles expected 0", rd_seen);
    end
    cpu_set(16'hFF46, 8'h00, 1'b0, 1'b1);
    checks++;
    if (bus.Do_mmu !== 8'h00) begin
      failures++;
      $display("FAIL reset_dma_reg_clear: got %h expected 00", bus.Do_mmu);
    end
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.A_mmu = 16'h0000; bus.Di_mmu = 8'h00; bus.wr_mmu = 1'b0; bus.rd_mmu = 1'b0;
    Di_vram = 8'h00; Di_oam = 8'h00; dma_Di = 8'h00;
    ppu_regs = '0; lcd_on = 1'b0; ppu_mode = 2'd0;
    test_reset();
    test_vram();
    test_oam_lock();
    test_decode();
    test_dma(8'hC1);
    test_dma(8'($urandom));
    test_restart();
    test_reset_mid_dma();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
